eth_header_tx_mc: RTL and testbench
===================================

Name: eth_header_tx_mc

Overview:
- Multi-channel, width-parametrised Ethernet II header serializer with optional 802.1Q VLAN tag insertion.
- On a start pulse from the preamble/SFD stage, it arbitrates among N_CH protocol clients and latches MAC addresses and tag.
- It then streams the 14- or 18-byte header over an AXI-Stream-style master with backpressure.
- It pulses a per-channel done so the granted payload generator (ARP, IPv4, ...) can follow.

Parameters:
- DATA_BYTES, 1, bytes per beat; legal values 1, 2, 4, 8.
- N_CH, 2, number of client channels; legal range 1..8.
- CH_TYPE, {16'h0806, 16'h0800}, per-channel EtherType, N_CH x 16 bits, index 0 first.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- hdr_start  in  1  one-cycle pulse: preamble/SFD finished.
- ch_req  in  N_CH  level requests; bit i = channel i wants this frame.
- mac_d_addr  in  48  destination MAC.
- mac_s_addr  in  48  source MAC.
- vlan_en  in  1  insert 802.1Q tag.
- vlan_tci  in  16  PCP/DEI/VID.
- m_tdata  out  8*DATA_BYTES  header bytes; byte lane 0 (bits 7:0) is first on wire.
- m_tkeep  out  DATA_BYTES  valid byte lanes.
- m_tvalid  out  1  beat valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  final header beat.
- ch_done  out  N_CH  one-hot, one-cycle pulse: header for granted channel sent.
- no_req_err  out  1  one-cycle pulse: hdr_start seen with ch_req == 0.
- busy  out  1  high from accepted start until ch_done.

Behaviour:
- Reset values:
  - m_tvalid, m_tlast, ch_done, no_req_err, busy = 0.
  - m_tdata, m_tkeep = 0.
  - FSM = IDLE; beat counter = 0.
- IDLE, on hdr_start with ch_req != 0:
  - Grant the lowest set index g (fixed priority; ARP beats IPv4).
  - Latch mac_d_addr, mac_s_addr, vlan_en, vlan_tci and CH_TYPE[g] into a 144-bit header register.
  - Go to SEND; busy = 1.
  - Later input changes do not affect the frame.
- IDLE, on hdr_start with ch_req == 0:
  - no_req_err pulses next cycle; stay in IDLE.
- Header byte order (big-endian fields, MSB byte first):
  - DA[47:40]..DA[7:0], then SA[47:40]..SA[7:0].
  - If vlan_en: 0x81, 0x00, TCI[15:8], TCI[7:0].
  - Then TYPE[15:8], TYPE[7:0].
- Lengths and beats:
  - HLEN = 14, or 18 with VLAN.
  - Beats = ceil(HLEN/DATA_BYTES).
  - DATA_BYTES=1: 14/18 beats. DATA_BYTES=2: 7/9. DATA_BYTES=4: 4/5. DATA_BYTES=8: 2/3.
- SEND:
  - m_tvalid = 1 starting the cycle after the start sample (latency 1).
  - m_tdata and m_tkeep are held stable while m_tvalid && !m_tready.
  - On each handshake, shift the header register by DATA_BYTES bytes and increment the beat counter.
  - m_tkeep is all ones except on the last beat, where it is (1<<(HLEN mod DATA_BYTES))-1 when that remainder is nonzero.
  - Unused lanes output 0.
  - m_tlast = 1 only on the final beat.
- Last-beat handshake:
  - Next cycle: m_tvalid = 0, ch_done[g] = 1 for one cycle, busy = 0, FSM = IDLE.
  - A new hdr_start is accepted in that same cycle (back-to-back frames, no gap requirement).
- hdr_start while busy: ignored, no error pulse, grant unchanged.
- ch_req dropping mid-frame: ignored; the frame completes and done goes to the latched grant.
- m_tready held low indefinitely: the block stalls with no timeout; data stays stable.
- aresetn low mid-frame:
  - All outputs return to reset values next edge.
  - No ch_done is issued; the partial header is abandoned.
- Beat counter is 5 bits, sized for the worst case of 18 beats; no wrap is possible.

Decomposition:
- Package eth_pkg:
  - ETH_TYPE_ARP = 16'h0806, ETH_TYPE_IPV4 = 16'h0800, ETH_TPID_VLAN = 16'h8100.
  - ETH_HDR_LEN = 14, ETH_VLAN_HDR_LEN = 18.
  - Header FSM state enum {IDLE, SEND}.
- One sub-module is natural: eth_prio_arb (N_CH-bit fixed-priority one-hot grant plus index). It is reused later by the payload mux.

Test Plan:
- DATA_BYTES=1, N_CH=2, ch_req=2'b11, vlan_en=0, tready=1, DA=FF:FF:FF:FF:FF:FF, SA=02:00:00:00:00:01 -> 14 beats FF x6, 02,00,00,00,00,01, 08,06; tlast on beat 14; ch_done=2'b01 one cycle later.
- DATA_BYTES=4, ch_req=2'b10, vlan_en=1, TCI=0x6064 -> 5 beats; beat 4 = bytes 81,00,60,64; beat 5 tdata[15:0] = bytes 08,00, tkeep=4'b0011, tlast=1; ch_done=2'b10.
- DATA_BYTES=8, random tready ~50% -> 2 beats; tdata/tkeep constant during every stall; beat 2 tkeep=8'h3F.
- hdr_start with ch_req=0 -> no_req_err pulse, m_tvalid stays 0, busy stays 0.
- hdr_start on the ch_done cycle with new DA -> the second frame starts one cycle later with the new DA; a mid-frame hdr_start and mid-frame changes to DA/ch_req are ignored.
- aresetn asserted on beat 3 of 14 -> m_tvalid=0, busy=0, no ch_done; the next hdr_start sends a full header from byte 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, header FSM states and the header packing helper.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TPID_VLAN = 16'h8100;

  localparam int ETH_HDR_LEN      = 14;
  localparam int ETH_VLAN_HDR_LEN = 18;
  localparam int ETH_HDR_BITS     = 8 * ETH_VLAN_HDR_LEN;

  typedef enum logic {
    IDLE,
    SEND
  } hdr_state_e;

  // Packs the header so that wire byte k sits at bits [8k+7:8k]; bytes past the
  // header length are zero, so shifting right always exposes zero-filled lanes.
  function automatic logic [ETH_HDR_BITS-1:0] pack_header(
    input logic [47:0] da,
    input logic [47:0] sa,
    input logic        vlan,
    input logic [15:0] tci,
    input logic [15:0] etype
  );
    logic [7:0]              b [ETH_VLAN_HDR_LEN];
    logic [ETH_HDR_BITS-1:0] h;
    for (int i = 0; i < 6; i++) begin
      b[i]     = da[47-8*i -: 8];
      b[6 + i] = sa[47-8*i -: 8];
    end
    if (vlan) begin
      b[12] = ETH_TPID_VLAN[15:8];
      b[13] = ETH_TPID_VLAN[7:0];
      b[14] = tci[15:8];
      b[15] = tci[7:0];
      b[16] = etype[15:8];
      b[17] = etype[7:0];
    end else begin
      b[12] = etype[15:8];
      b[13] = etype[7:0];
      b[14] = 8'h00;
      b[15] = 8'h00;
      b[16] = 8'h00;
      b[17] = 8'h00;
    end
    h = '0;
    for (int k = 0; k < ETH_VLAN_HDR_LEN; k++) begin
      h[8*k +: 8] = b[k];
    end
    return h;
  endfunction

endpackage

// File: rtl/eth_prio_arb.sv
// Fixed-priority arbiter: the lowest set request wins; returns one-hot and index.
module eth_prio_arb #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest requesting index is the last to win.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves one
    // unassigned would infer a latch.
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/eth_header_tx_mc.sv
// Multi-channel Ethernet II header serializer with optional 802.1Q tag.
// Arbitrates clients on hdr_start, latches the header, streams it over an
// AXI-Stream-style master and pulses ch_done to the granted client.
module eth_header_tx_mc
  import eth_pkg::*;
#(
  parameter int                    DATA_BYTES = 1,
  parameter int                    N_CH       = 2,
  // Channel i's EtherType lives in CH_TYPE[i]; channel 0 is the low slot.
  parameter logic [N_CH-1:0][15:0] CH_TYPE    = {ETH_TYPE_IPV4, ETH_TYPE_ARP}
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    hdr_start,
  input  logic [N_CH-1:0]         ch_req,
  input  logic [47:0]             mac_d_addr,
  input  logic [47:0]             mac_s_addr,
  input  logic                    vlan_en,
  input  logic [15:0]             vlan_tci,
  output logic [8*DATA_BYTES-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [N_CH-1:0]         ch_done,
  output logic                    no_req_err,
  output logic                    busy
);

  localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LANE_W     = 8 * DATA_BYTES;
  localparam int BEATS_STD  = (ETH_HDR_LEN + DATA_BYTES - 1) / DATA_BYTES;
  localparam int BEATS_VLAN = (ETH_VLAN_HDR_LEN + DATA_BYTES - 1) / DATA_BYTES;
  localparam int REM_STD    = ETH_HDR_LEN % DATA_BYTES;
  localparam int REM_VLAN   = ETH_VLAN_HDR_LEN % DATA_BYTES;

  localparam logic [4:0] LAST_STD  = 5'(BEATS_STD - 1);
  localparam logic [4:0] LAST_VLAN = 5'(BEATS_VLAN - 1);

  localparam logic [DATA_BYTES-1:0] KEEP_FULL = '1;
  localparam logic [DATA_BYTES-1:0] KEEP_STD  =
    (REM_STD == 0) ? KEEP_FULL : DATA_BYTES'((1 << REM_STD) - 1);
  localparam logic [DATA_BYTES-1:0] KEEP_VLAN =
    (REM_VLAN == 0) ? KEEP_FULL : DATA_BYTES'((1 << REM_VLAN) - 1);

  hdr_state_e              state_q, state_d;
  logic [ETH_HDR_BITS-1:0] hdr_q, hdr_d;
  logic [4:0]              beat_q, beat_d;
  logic                    vlan_q, vlan_d;
  logic [N_CH-1:0]         grant_q, grant_d;
  logic [N_CH-1:0]         done_q, done_d;
  logic                    err_q, err_d;

  logic [N_CH-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             sending;
  logic             is_last;

  eth_prio_arb #(.N(N_CH)) u_arb (
    .req   (ch_req),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sending = (state_q == SEND);
  assign is_last = vlan_q ? (beat_q == LAST_VLAN) : (beat_q == LAST_STD);

  // Next-state: accept a start in IDLE, advance one beat per handshake in SEND.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    beat_d  = beat_q;
    vlan_d  = vlan_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hdr_start) begin
          if (arb_any) begin
            state_d = SEND;
            hdr_d   = pack_header(mac_d_addr, mac_s_addr, vlan_en, vlan_tci,
                                  CH_TYPE[arb_idx]);
            beat_d  = '0;
            vlan_d  = vlan_en;
            grant_d = arb_grant;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (m_tready) begin
          if (is_last) begin
            state_d = IDLE;
            beat_d  = '0;
            done_d  = grant_q;
          end else begin
            hdr_d  = hdr_q >> LANE_W;
            beat_d = beat_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering. The header
    // register is cleared too: an abandoned frame must never leak bytes.
    if (!aresetn) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      beat_q  <= '0;
      vlan_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      beat_q  <= beat_d;
      vlan_q  <= vlan_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Stream outputs are driven only while sending; lanes past the header are zero.
  always_comb begin
    m_tvalid = sending;
    busy     = sending;
    m_tdata  = sending ? hdr_q[LANE_W-1:0] : '0;
    m_tlast  = sending && is_last;
    m_tkeep  = '0;
    if (sending) begin
      m_tkeep = is_last ? (vlan_q ? KEEP_VLAN : KEEP_STD) : KEEP_FULL;
    end
  end

  assign ch_done    = done_q;
  assign no_req_err = err_q;

endmodule

// File: tb/tb_eth_header_tx_mc.sv
// Bench for eth_header_tx_mc: three instances (1, 4 and 8 bytes per beat) share
// stimulus; a byte-position model predicts every output each cycle, and literal
// expectations pin the model on the documented frames.
module tb_eth_header_tx_mc;

  localparam int NI = 3;

  localparam logic [7:0] SC1 [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                      8'h08, 8'h06};

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          hdr_start = 1'b0;
  logic [1:0]    ch_req = '0;
  logic [47:0]   da = '0;
  logic [47:0]   sa = '0;
  logic          vlan_en = 1'b0;
  logic [15:0]   tci = '0;
  logic [NI-1:0] tready = '1;
  bit            rdy_rand = 1'b0;

  logic [63:0] o_tdata [NI];
  logic [7:0]  o_tkeep [NI];
  logic        o_tvalid[NI];
  logic        o_tlast [NI];
  logic        o_err   [NI];
  logic        o_busy  [NI];
  logic [1:0]  o_done  [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int DB = (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    logic [8*DB-1:0] tdata;
    logic [DB-1:0]   tkeep;
    logic            tvalid, tlast, err, bsy;
    logic [1:0]      done;

    eth_header_tx_mc #(.DATA_BYTES(DB), .N_CH(2)) u_dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .hdr_start  (hdr_start),
      .ch_req     (ch_req),
      .mac_d_addr (da),
      .mac_s_addr (sa),
      .vlan_en    (vlan_en),
      .vlan_tci   (tci),
      .m_tdata    (tdata),
      .m_tkeep    (tkeep),
      .m_tvalid   (tvalid),
      .m_tready   (tready[k]),
      .m_tlast    (tlast),
      .ch_done    (done),
      .no_req_err (err),
      .busy       (bsy)
    );

    assign o_tdata[k]  = 64'(tdata);
    assign o_tkeep[k]  = 8'(tkeep);
    assign o_tvalid[k] = tvalid;
    assign o_tlast[k]  = tlast;
    assign o_err[k]    = err;
    assign o_busy[k]   = bsy;
    assign o_done[k]   = done;
  end

  // Model state: which header byte is on lane 0, and the frame's bytes.
  bit         m_busy[NI];
  int         m_pos [NI];
  int         m_hlen[NI];
  int         m_g   [NI];
  logic [7:0] m_hdr [NI][18];
  logic [1:0] m_done[NI];
  bit         m_err [NI];

  logic [63:0] cap_d[NI][24];
  logic [7:0]  cap_k[NI][24];
  bit          cap_l[NI][24];
  int          cap_n[NI];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  function automatic int db_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the inputs seen at that edge.
  task automatic model_step();
    logic [15:0] et;
    for (int k = 0; k < NI; k++) begin
      if (!aresetn) begin
        m_busy[k] = 1'b0;
        m_done[k] = '0;
        m_err[k]  = 1'b0;
      end else begin
        m_done[k] = '0;
        m_err[k]  = 1'b0;
        if (m_busy[k]) begin
          if (tready[k]) begin
            m_pos[k] += db_of(k);
            if (m_pos[k] >= m_hlen[k]) begin
              m_busy[k] = 1'b0;
              m_done[k] = 2'b01 << m_g[k];
            end
          end
        end else if (hdr_start) begin
          if (ch_req == 2'b00) begin
            m_err[k] = 1'b1;
          end else begin
            m_g[k] = ch_req[0] ? 0 : 1;
            et = (m_g[k] == 0) ? 16'h0806 : 16'h0800;
            for (int i = 0; i < 6; i++) begin
              m_hdr[k][i]     = da[47-8*i -: 8];
              m_hdr[k][6 + i] = sa[47-8*i -: 8];
            end
            if (vlan_en) begin
              m_hdr[k][12] = 8'h81;
              m_hdr[k][13] = 8'h00;
              m_hdr[k][14] = tci[15:8];
              m_hdr[k][15] = tci[7:0];
              m_hdr[k][16] = et[15:8];
              m_hdr[k][17] = et[7:0];
              m_hlen[k]    = 18;
            end else begin
              m_hdr[k][12] = et[15:8];
              m_hdr[k][13] = et[7:0];
              m_hlen[k]    = 14;
            end
            m_pos[k]  = 0;
            m_busy[k] = 1'b1;
            cap_n[k]  = 0;
          end
        end
      end
    end
  endtask

  // Compare every output of every instance against the model; capture beats.
  task automatic compare_step();
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        el;
    int          db;
    for (int k = 0; k < NI; k++) begin
      db = db_of(k);
      if (o_tvalid[k] && tready[k] && cap_n[k] < 24) begin
        cap_d[k][cap_n[k]] = o_tdata[k];
        cap_k[k][cap_n[k]] = o_tkeep[k];
        cap_l[k][cap_n[k]] = o_tlast[k];
        cap_n[k]++;
      end
      ed = '0;
      ek = '0;
      el = 1'b0;
      if (m_busy[k]) begin
        for (int l = 0; l < db; l++) begin
          if (m_pos[k] + l < m_hlen[k]) begin
            ed[8*l +: 8] = m_hdr[k][m_pos[k] + l];
            ek[l]        = 1'b1;
          end
        end
        el = (m_pos[k] + db >= m_hlen[k]);
      end
      check($sformatf("tdata[%0d]", k),  o_tdata[k],         ed);
      check($sformatf("tkeep[%0d]", k),  64'(o_tkeep[k]),    64'(ek));
      check($sformatf("tvalid[%0d]", k), 64'(o_tvalid[k]),   64'(m_busy[k]));
      check($sformatf("tlast[%0d]", k),  64'(o_tlast[k]),    64'(el));
      check($sformatf("busy[%0d]", k),   64'(o_busy[k]),     64'(m_busy[k]));
      check($sformatf("ch_done[%0d]", k), 64'(o_done[k]),    64'(m_done[k]));
      check($sformatf("no_req_err[%0d]", k), 64'(o_err[k]),  64'(m_err[k]));
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    tready = rdy_rand ? NI'($urandom) : '1;
  endtask

  task automatic pulse_start();
    hdr_start = 1'b1;
    tick();
    hdr_start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (n < max && (o_busy[0] || o_busy[1] || o_busy[2])) begin
      tick();
      n++;
    end
    check("idle before cycle budget", {61'b0, o_busy[2], o_busy[1], o_busy[0]}, 64'h0);
    tick();
    tick();
  endtask

  initial begin
    int n;
    fork
      forever begin
        @(posedge aclk);
        model_step();
      end
      forever begin
        @(negedge aclk);
        if (chk_en) compare_step();
      end
    join_none

    // Reset state is compared while aresetn is still low.
    @(posedge aclk);
    #1 chk_en = 1'b1;
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    // Broadcast ARP header, both channels requesting, no tag.
    ch_req = 2'b11; vlan_en = 1'b0;
    da = 48'hFFFF_FFFF_FFFF; sa = 48'h0200_0000_0001;
    pulse_start();
    wait_idle(60);
    check("sc1 beats db1", 64'(cap_n[0]), 64'd14);
    for (int i = 0; i < 14; i++) begin
      check($sformatf("sc1 byte %0d", i), cap_d[0][i], 64'(SC1[i]));
    end
    check("sc1 tlast beat14", 64'(cap_l[0][13]), 64'd1);
    check("sc1 tlast beat13", 64'(cap_l[0][12]), 64'd0);
    check("sc1 beats db4", 64'(cap_n[1]), 64'd4);
    check("sc1 keep db4 last", 64'(cap_k[1][3]), 64'h03);
    check("sc1 beats db8", 64'(cap_n[2]), 64'd2);
    check("sc1 keep db8 last", 64'(cap_k[2][1]), 64'h3F);

    // IPv4 channel only, VLAN tag inserted.
    ch_req = 2'b10; vlan_en = 1'b1; tci = 16'h6064;
    da = 48'h0011_2233_4455;
    pulse_start();
    wait_idle(60);
    check("sc2 beats db4", 64'(cap_n[1]), 64'd5);
    check("sc2 beat4 db4", cap_d[1][3], 64'h0000_0000_6460_0081);
    check("sc2 beat5 db4", cap_d[1][4], 64'h0000_0000_0000_0008);
    check("sc2 keep5 db4", 64'(cap_k[1][4]), 64'h03);
    check("sc2 last5 db4", 64'(cap_l[1][4]), 64'd1);
    check("sc2 beats db1", 64'(cap_n[0]), 64'd18);

    // Random backpressure, no tag.
    ch_req = 2'b11; vlan_en = 1'b0;
    rdy_rand = 1'b1;
    pulse_start();
    wait_idle(300);
    rdy_rand = 1'b0;
    tick();
    check("sc3 beats db8", 64'(cap_n[2]), 64'd2);
    check("sc3 beat2 db8", cap_d[2][1], 64'h0000_0608_0100_0000);
    check("sc3 keep2 db8", 64'(cap_k[2][1]), 64'h3F);

    // Start with no requester.
    ch_req = 2'b00;
    pulse_start();
    @(negedge aclk);
    check("sc4 no_req_err", 64'(o_err[0]), 64'd1);
    check("sc4 tvalid", 64'(o_tvalid[0]), 64'd0);
    check("sc4 busy", 64'(o_busy[1]), 64'd0);
    tick();
    tick();

    // Mid-frame start/DA/ch_req changes ignored; back-to-back start on ch_done.
    ch_req = 2'b01; da = 48'hAAAA_AAAA_AAAA;
    pulse_start();
    tick();
    tick();
    da = 48'hBBBB_BBBB_BBBB; ch_req = 2'b10; hdr_start = 1'b1;
    tick();
    hdr_start = 1'b0;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (o_done[0] == 2'b00 && n < 40);
    check("sc5 done db1 frame1", 64'(o_done[0]), 64'h1);
    da = 48'h1122_3344_5566;
    hdr_start = 1'b1;
    @(posedge aclk);
    #1 hdr_start = 1'b0;
    check("sc5 frame2 accepted", 64'(o_busy[0]), 64'd1);
    wait_idle(60);
    check("sc5 beats db1", 64'(cap_n[0]), 64'd14);
    check("sc5 first byte", cap_d[0][0], 64'h11);
    check("sc5 type hi", cap_d[0][12], 64'h08);
    check("sc5 type lo", cap_d[0][13], 64'h00);

    // Reset on beat 3 abandons the frame; the next one starts from byte 0.
    ch_req = 2'b01; da = 48'hCAFE_0000_BEEF;
    pulse_start();
    tick();
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    check("sc6 tvalid after reset", 64'(o_tvalid[0]), 64'd0);
    check("sc6 busy after reset", 64'(o_busy[0]), 64'd0);
    check("sc6 no done after reset", 64'(o_done[0]), 64'd0);
    tick();
    pulse_start();
    wait_idle(60);
    check("sc6 beats db1", 64'(cap_n[0]), 64'd14);
    check("sc6 first byte", cap_d[0][0], 64'hCA);
    check("sc6 last byte", cap_d[0][13], 64'h06);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
